axis_tkeep_frame_tx: RTL and testbench
======================================

Name: axis_tkeep_frame_tx

Overview:
- AXI-Stream frame transmitter: the source end of the tdata/tkeep/tlast stream that the tkeep FSM consumes.
- Takes a command (byte length plus starting byte value) and emits the frame as full-width beats.
- On the final beat, tkeep is trimmed to the residual byte count and tlast is asserted.
- Used as a synthesizable traffic source in front of tkeep-processing blocks and in loopback benches.

Parameters:
- DW, 64, m_tdata width in bits; must be a multiple of 8.
- KW, DW/8, m_tkeep width (byte lanes); must equal DW/8.
- LW, 16, width of the frame length field in bytes.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  frame command valid.
- cmd_ready  output  1  command accept; high only in IDLE.
- cmd_len  input  LW  frame length in bytes; 0 is illegal.
- cmd_seed  input  8  value of byte 0 of the frame.
- m_tvalid  output  1  AXIS beat valid.
- m_tdata  output  DW  AXIS data; lane k = bits [8k+7:8k].
- m_tkeep  output  KW  AXIS byte-keep.
- m_tlast  output  1  last beat of frame.
- m_tready  input  1  AXIS downstream ready.
- busy  output  1  high in SEND.
- frame_done  output  1  one-cycle pulse on the cycle after the tlast beat handshake.
- err_len  output  1  one-cycle pulse after a zero-length command is accepted.
- frame_cnt  output  16  count of completed frames; wraps 0xFFFF -> 0.

Behaviour:
- Reset (rst=0, async): state=IDLE; m_tvalid, m_tdata, m_tkeep, m_tlast, busy, frame_done, err_len and frame_cnt are all 0. Internal counters are cleared.
- cmd_ready is decoded from state (IDLE -> 1). Commands presented while rst=0 are ignored.
- States: IDLE, SEND.
- IDLE:
  - cmd_ready=1, m_tvalid=0.
  - On cmd_valid with cmd_len==0: err_len=1 next cycle, remain in IDLE, no beats emitted.
  - On cmd_valid with cmd_len!=0: latch the command, compute beats = ceil(cmd_len/KW) and rem = cmd_len mod KW, go to SEND.
  - The first beat is valid on the next cycle (latency 1 from command accept).
- SEND:
  - m_tvalid=1, cmd_ready=0, busy=1.
  - Byte i of the frame = (cmd_seed + i) mod 256; the counter wraps 0xFF -> 0x00.
  - Beat b carries bytes b*KW .. b*KW+KW-1, lowest-index byte in lane 0.
  - Non-final beats: m_tkeep = all ones, m_tlast = 0.
  - Final beat: m_tlast = 1. If rem==0, m_tkeep = all ones; otherwise only the low rem bits are set.
  - Lanes with tkeep=0 drive 0x00.
- Handshake:
  - A beat transfers when m_tvalid & m_tready.
  - While m_tvalid=1 and m_tready=0, m_tdata, m_tkeep and m_tlast hold stable and m_tvalid stays high; there is no retraction.
  - On transfer of a non-final beat, the next beat is presented the following cycle. Full throughput is 1 beat/cycle under continuous m_tready.
- Frame end:
  - On transfer of the tlast beat: go to IDLE, m_tvalid=0 next cycle, frame_done=1 for one cycle, frame_cnt increments.
  - There is a minimum one idle cycle between frames, because cmd_ready is only high in IDLE.
- Single-beat frame (cmd_len <= KW): the first beat carries tlast.
- Maximum length 2^LW-1 bytes. Beat and byte counters must be sized to hold it without overflow.
- Reset mid-frame: the frame is abandoned immediately and all outputs return to reset values. No tlast is emitted and frame_cnt is not incremented.
- m_tready is ignored in IDLE.

Test Plan:
- Reset then idle: rst low 3 cycles, release -> all outputs 0, cmd_ready=1, no m_tvalid for 10 cycles.
- Full-beat frame: cmd_len=16, cmd_seed=0x00, m_tready=1 -> 2 beats.
  - Beat 0: tdata=0x0706050403020100, tkeep=0xFF, tlast=0.
  - Beat 1: tdata=0x0F0E0D0C0B0A0908, tkeep=0xFF, tlast=1.
  - Then frame_done pulse, frame_cnt=1.
- Partial last beat with seed wrap: cmd_len=13, cmd_seed=0xFE -> 2 beats.
  - Beat 0: tdata=0x0504030201_00FFFE, tkeep=0xFF.
  - Beat 1: tdata=0x0000000A09080706, tkeep=0x1F, tlast=1.
- Single byte and zero length:
  - cmd_len=1, seed=0x5A -> one beat, tdata=0x5A, tkeep=0x01, tlast=1.
  - cmd_len=0 -> err_len pulse, no m_tvalid, frame_cnt unchanged.
- Backpressure: cmd_len=24, m_tready toggling 1,0,0,1,0,1 -> 3 beats delivered in order, each held stable across stall cycles, tkeep=0xFF on all, tlast on beat 2 only.
- Reset mid-frame: cmd_len=64, deassert m_tready after 3 beats, assert rst -> m_tvalid drops asynchronously, no frame_done, frame_cnt=0; after release, a new cmd_len=8 frame sends cleanly.

Source files
------------

// File: rtl/axis_tkeep_frame_tx.sv
// AXI-Stream frame transmitter.
// Accepts a (length, seed) command in IDLE and emits the frame as full-width
// beats whose byte i carries (seed + i) mod 256. The final beat carries tlast
// and a tkeep trimmed to the residual byte count; unkept lanes drive 0x00.
// All stream outputs come straight from flops so they hold during stalls.
module axis_tkeep_frame_tx #(
  parameter int DW = 64,
  parameter int KW = DW / 8,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [LW-1:0] cmd_len,
  input  logic [7:0]    cmd_seed,
  output logic          m_tvalid,
  output logic [DW-1:0] m_tdata,
  output logic [KW-1:0] m_tkeep,
  output logic          m_tlast,
  input  logic          m_tready,
  output logic          busy,
  output logic          frame_done,
  output logic          err_len,
  output logic [15:0]   frame_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Number of bytes that live on a beat: KW for every beat except a final beat
  // with a non-zero residual, which carries only rem bytes.
  function automatic logic [LW-1:0] lane_count(input logic          is_last,
                                               input logic [LW-1:0] rem);
    logic [LW-1:0] n;
    if (is_last && (rem != {LW{1'b0}})) begin
      n = rem;
    end else begin
      n = LW'(KW);
    end
    return n;
  endfunction

  // Beat payload: lane k holds start + k for the first n lanes, zero above.
  function automatic logic [DW-1:0] beat_data(input logic [7:0]    start,
                                              input logic [LW-1:0] n);
    logic [DW-1:0] d;
    d = {DW{1'b0}};
    for (int k = 0; k < KW; k++) begin
      if (LW'(k) < n) begin
        d[8*k +: 8] = start + 8'(k);
      end else begin
        d[8*k +: 8] = 8'h00;
      end
    end
    return d;
  endfunction

  // Byte-keep for a beat carrying n bytes starting at lane 0.
  function automatic logic [KW-1:0] beat_keep(input logic [LW-1:0] n);
    logic [KW-1:0] kp;
    kp = {KW{1'b0}};
    for (int k = 0; k < KW; k++) begin
      kp[k] = (LW'(k) < n);
    end
    return kp;
  endfunction

  state_t        state_q,      state_d;
  logic [LW-1:0] beats_left_q, beats_left_d;  // beats still to transfer, incl. the one on the bus
  logic [LW-1:0] rem_q,        rem_d;         // residual bytes of the final beat (0 = full)
  logic [7:0]    next_byte_q,  next_byte_d;   // value of the first byte of the next beat
  logic [DW-1:0] m_tdata_q,    m_tdata_d;
  logic [KW-1:0] m_tkeep_q,    m_tkeep_d;
  logic          m_tlast_q,    m_tlast_d;
  logic          frame_done_q, frame_done_d;
  logic          err_len_q,    err_len_d;
  logic [15:0]   frame_cnt_q,  frame_cnt_d;

  // Temporaries for the beat being built this cycle.
  logic [LW:0]   beats_sum_s;
  logic [LW-1:0] beats_s;
  logic [LW-1:0] n_s;
  logic          last_s;

  // Next-state, beat construction and status pulses.
  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    rem_d        = rem_q;
    next_byte_d  = next_byte_q;
    m_tdata_d    = m_tdata_q;
    m_tkeep_d    = m_tkeep_q;
    m_tlast_d    = m_tlast_q;
    frame_done_d = 1'b0;
    err_len_d    = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    beats_sum_s  = {1'b0, cmd_len} + (LW+1)'(KW - 1);
    beats_s      = LW'(beats_sum_s / (LW+1)'(KW));
    n_s          = {LW{1'b0}};
    last_s       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_len == {LW{1'b0}}) begin
            // Zero-length frames are rejected without leaving IDLE.
            err_len_d = 1'b1;
          end else begin
            // Latch the command and present beat 0 on the next cycle.
            rem_d        = cmd_len % LW'(KW);
            last_s       = (beats_s == LW'(1));
            n_s          = lane_count(last_s, rem_d);
            m_tdata_d    = beat_data(cmd_seed, n_s);
            m_tkeep_d    = beat_keep(n_s);
            m_tlast_d    = last_s;
            beats_left_d = beats_s;
            next_byte_d  = cmd_seed + 8'(n_s);
            state_d      = ST_SEND;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SEND: begin
        if (m_tready) begin
          if (m_tlast_q) begin
            // Final beat accepted: close the frame and blank the bus.
            state_d      = ST_IDLE;
            beats_left_d = {LW{1'b0}};
            m_tdata_d    = {DW{1'b0}};
            m_tkeep_d    = {KW{1'b0}};
            m_tlast_d    = 1'b0;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
          end else begin
            // Non-final beat accepted: build the following beat immediately.
            last_s       = (beats_left_q == LW'(2));
            n_s          = lane_count(last_s, rem_q);
            m_tdata_d    = beat_data(next_byte_q, n_s);
            m_tkeep_d    = beat_keep(n_s);
            m_tlast_d    = last_s;
            beats_left_d = beats_left_q - LW'(1);
            next_byte_d  = next_byte_q + 8'(n_s);
          end
        end else begin
          // Stalled: every stream output holds.
          state_d = ST_SEND;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      beats_left_q <= {LW{1'b0}};
      rem_q        <= {LW{1'b0}};
      next_byte_q  <= 8'h00;
      m_tdata_q    <= {DW{1'b0}};
      m_tkeep_q    <= {KW{1'b0}};
      m_tlast_q    <= 1'b0;
      frame_done_q <= 1'b0;
      err_len_q    <= 1'b0;
      frame_cnt_q  <= 16'h0000;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      rem_q        <= rem_d;
      next_byte_q  <= next_byte_d;
      m_tdata_q    <= m_tdata_d;
      m_tkeep_q    <= m_tkeep_d;
      m_tlast_q    <= m_tlast_d;
      frame_done_q <= frame_done_d;
      err_len_q    <= err_len_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign m_tvalid   = (state_q == ST_SEND);
  assign busy       = (state_q == ST_SEND);
  assign m_tdata    = m_tdata_q;
  assign m_tkeep    = m_tkeep_q;
  assign m_tlast    = m_tlast_q;
  assign frame_done = frame_done_q;
  assign err_len    = err_len_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_axis_tkeep_frame_tx.sv
// Scoreboard bench for axis_tkeep_frame_tx: commands push the expected beats
// of each frame (computed byte by byte) into a queue; a negedge monitor pops
// and compares on every handshake and checks the status pulses and counter.
module tb_axis_tkeep_frame_tx;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len;
  logic [7:0]    cmd_seed;
  logic          m_tvalid;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tlast;
  logic          m_tready;
  logic          busy;
  logic          frame_done;
  logic          err_len;
  logic [15:0]   frame_cnt;

  axis_tkeep_frame_tx #(.DW(DW), .KW(KW), .LW(LW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_seed(cmd_seed),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tready(m_tready), .busy(busy), .frame_done(frame_done), .err_len(err_len),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;
  int    exp_cnt = 0;
  int    rdy_mode = 0;   // 0: always ready, 1: random, 2: fixed pattern, 3: driven by stimulus
  int    pat_i = 0;
  logic  pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: byte i = (seed + i) mod 256, packed KW bytes per beat.
  task automatic push_frame(input int len, input int seed);
    int nb;
    beat_t bt;
    nb = (len + KW - 1) / KW;
    for (int b = 0; b < nb; b++) begin
      bt.d = '0;
      bt.k = '0;
      for (int j = 0; j < KW; j++) begin
        int idx;
        idx = b * KW + j;
        if (idx < len) begin
          bt.d[8*j +: 8] = 8'((seed + idx) % 256);
          bt.k[j] = 1'b1;
        end
      end
      bt.l = (b == nb - 1);
      exp_q.push_back(bt);
    end
  endtask

  // Downstream ready generator.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: m_tready = 1'b1;
      1: m_tready = ($urandom_range(0, 3) != 0);
      2: begin
        if (pat_i < 6) begin
          m_tready = pat[pat_i];
          pat_i++;
        end else begin
          m_tready = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Monitor: scoreboard pops on handshake, status pulses, stall stability.
  logic          done_pend = 1'b0;
  logic          err_pend  = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_d;
  logic [KW-1:0] prev_k;
  logic          prev_l;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      check("frame_done", frame_done, done_pend);
      check("frame_cnt", frame_cnt, 64'(exp_cnt));
      check("err_len", err_len, err_pend);
      check("busy_vs_valid", busy, m_tvalid);
      check("cmd_ready_vs_valid", cmd_ready, !m_tvalid);
      if (prev_stall) begin
        check("hold_valid", m_tvalid, 1'b1);
        check("hold_data", m_tdata, prev_d);
        check("hold_keep", m_tkeep, prev_k);
        check("hold_last", m_tlast, prev_l);
      end
      done_pend = 1'b0;
      err_pend  = cmd_valid && cmd_ready && (cmd_len == '0);
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 64'd1, 64'd0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", m_tdata, e.d);
          check("beat_keep", m_tkeep, e.k);
          check("beat_last", m_tlast, e.l);
          if (e.l) begin
            done_pend = 1'b1;
            exp_cnt = (exp_cnt + 1) % 65536;
          end
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_d = m_tdata;
      prev_k = m_tkeep;
      prev_l = m_tlast;
    end else begin
      done_pend  = 1'b0;
      err_pend   = 1'b0;
      prev_stall = 1'b0;
      exp_cnt    = 0;
    end
  end

  // Present one command once the transmitter is idle.
  task automatic send_cmd(input int len, input int seed);
    int w;
    w = 0;
    @(posedge clk); #1;
    while (!cmd_ready && w < 20000) begin
      @(posedge clk); #1;
      w++;
    end
    if (!cmd_ready) begin
      check("cmd_ready_timeout", cmd_ready, 1'b1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_len   = LW'(len);
    cmd_seed  = 8'(seed);
    if (len != 0) push_frame(len, seed);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_len   = LW'($urandom);
  endtask

  // Wait until every expected beat is out, then let the done pulse be seen.
  task automatic drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || m_tvalid) && w < 20000) begin
      @(posedge clk); #1;
      w++;
    end
    check("drain", (exp_q.size() == 0) && !m_tvalid, 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_len = '0; cmd_seed = 8'h00; m_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", m_tvalid, 1'b0);
    check("rst_tdata", m_tdata, 64'h0);
    check("rst_tkeep", m_tkeep, 8'h00);
    check("rst_tlast", m_tlast, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", frame_done, 1'b0);
    check("rst_err", err_len, 1'b0);
    check("rst_cnt", frame_cnt, 16'h0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle_tvalid", m_tvalid, 1'b0);
      check("idle_cmd_ready", cmd_ready, 1'b1);
    end

    // Directed frames.
    send_cmd(16, 8'h00); drain();
    send_cmd(13, 8'hFE); drain();
    send_cmd(1, 8'h5A);  drain();
    send_cmd(0, 8'h33);  drain();
    pat_i = 0; rdy_mode = 2;
    send_cmd(24, 8'h40); drain();
    rdy_mode = 0;

    // Reset in the middle of a 64-byte frame after three beats.
    rdy_mode = 3; m_tready = 1'b1;
    send_cmd(64, 8'h03);
    repeat (3) @(posedge clk);
    #1 m_tready = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_tvalid", m_tvalid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_tdata", m_tdata, 64'h0);
    check("midrst_tkeep", m_tkeep, 8'h00);
    check("midrst_tlast", m_tlast, 1'b0);
    check("midrst_done", frame_done, 1'b0);
    check("midrst_cnt", frame_cnt, 16'h0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1; rdy_mode = 0;
    send_cmd(8, 8'h11); drain();

    // Random commands under random backpressure, some back to back.
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      int len;
      len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 70));
      send_cmd(len, int'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 0) drain();
    end
    drain();

    // Maximum-length frame at full throughput.
    rdy_mode = 0;
    send_cmd(65535, 8'h80); drain();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
